// File: rtl/bus_host_arbiter_if.sv
// Host-side and bus-side signal bundle of the multi-host bus arbiter.
// slave: the arbiter's view; master: the requesters plus downstream bus driving it.
interface bus_host_arbiter_if #(
  parameter int NrHosts      = 2,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);
  logic [NrHosts-1:0]              host_req_i;
  logic [NrHosts-1:0]              host_gnt_o;
  logic [NrHosts*AddressWidth-1:0] host_addr_i;
  logic [NrHosts-1:0]              host_we_i;
  logic [NrHosts*4-1:0]            host_be_i;
  logic [NrHosts*DataWidth-1:0]    host_wdata_i;
  logic [NrHosts-1:0]              host_rvalid_o;
  logic [DataWidth-1:0]            host_rdata_o;
  logic [NrHosts-1:0]              host_err_o;

  logic                            bus_req_o;
  logic                            bus_gnt_i;
  logic [AddressWidth-1:0]         bus_addr_o;
  logic                            bus_we_o;
  logic [3:0]                      bus_be_o;
  logic [DataWidth-1:0]            bus_wdata_o;
  logic                            bus_rvalid_i;
  logic [DataWidth-1:0]            bus_rdata_i;
  logic                            bus_err_i;

  logic                            unexp_rsp_o;

  modport slave (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    output bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i,
    output unexp_rsp_o
  );

  modport master (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    input  bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i,
    input  unexp_rsp_o
  );
endinterface

// File: rtl/bus_host_arbiter.sv
// Shares one bus host port among NrHosts requesters (round-robin, or lowest index with BUS_ARB_FIXED_PRIO_EN).
// Latency: request forwarding and response routing are combinational; only arbitration state and the ID FIFO are registered.
// Backpressure: requesters hold req until bus_gnt_i; all are stalled while MaxOutstanding responses are pending.
module bus_host_arbiter #(
  parameter int NrHosts        = 2,
  parameter int MaxOutstanding = 2,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  bus_host_arbiter_if.slave bus_if
);

  localparam int IdW  = $clog2(NrHosts);
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding) + 1;

  localparam logic [NrHosts-1:0] HostOne = NrHosts'(1);
  localparam logic [CntW-1:0]    CntFull = CntW'(MaxOutstanding);

  typedef struct packed {
    logic [AddressWidth-1:0] addr;
    logic                    we;
    logic [3:0]              be;
    logic [DataWidth-1:0]    wdata;
  } req_t;

  logic [IdW-1:0]  sel;
  logic            any_req;
  logic            blocked;
  logic            accept;
  logic            pop;
  req_t            sel_req;
  req_t            fwd_req;

  logic [IdW-1:0]  id_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            unexp_q;
  logic [IdW-1:0]  head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (MaxOutstanding == 1) ? '0 : p + 1'b1;
  endfunction

`ifdef BUS_ARB_FIXED_PRIO_EN
  always_comb begin
    sel = '0;
    for (int i = NrHosts - 1; i >= 0; i--) begin
      if (bus_if.host_req_i[i]) sel = IdW'(i);
    end
  end
`else
  logic [IdW-1:0] rr_ptr;

  // Scan downward so the requester closest above rr_ptr is the last one written.
  always_comb begin
    logic [IdW:0] j;
    j   = '0;
    sel = '0;
    for (int i = NrHosts - 1; i >= 0; i--) begin
      j = {1'b0, rr_ptr} + (IdW+1)'(i);
      if (j >= (IdW+1)'(NrHosts)) j = j - (IdW+1)'(NrHosts);
      if (bus_if.host_req_i[j[IdW-1:0]]) sel = j[IdW-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (sel == IdW'(NrHosts - 1)) ? '0 : sel + 1'b1;
    end
  end
`endif

  always_comb begin
    sel_req = '0;
    for (int i = 0; i < NrHosts; i++) begin
      if (sel == IdW'(i)) begin
        sel_req.addr  = bus_if.host_addr_i[i*AddressWidth +: AddressWidth];
        sel_req.we    = bus_if.host_we_i[i];
        sel_req.be    = bus_if.host_be_i[i*4 +: 4];
        sel_req.wdata = bus_if.host_wdata_i[i*DataWidth +: DataWidth];
      end
    end
  end

  // Blocking looks only at the registered count, so a same-cycle pop cannot free a slot.
  assign any_req          = |bus_if.host_req_i;
  assign blocked          = (count_q == CntFull);
  assign bus_if.bus_req_o = any_req & ~blocked;
  assign accept           = bus_if.bus_req_o & bus_if.bus_gnt_i;
  assign fwd_req          = bus_if.bus_req_o ? sel_req : '0;

  assign bus_if.bus_addr_o  = fwd_req.addr;
  assign bus_if.bus_we_o    = fwd_req.we;
  assign bus_if.bus_be_o    = fwd_req.be;
  assign bus_if.bus_wdata_o = fwd_req.wdata;
  assign bus_if.host_gnt_o  = accept ? (HostOne << sel) : '0;

  assign pop  = bus_if.bus_rvalid_i & (count_q != '0);
  assign head = id_q[rd_ptr_q];

  assign bus_if.host_rvalid_o = pop ? (HostOne << head) : '0;
  assign bus_if.host_err_o    = (pop & bus_if.bus_err_i) ? (HostOne << head) : '0;
  assign bus_if.host_rdata_o  = bus_if.bus_rdata_i;
  assign bus_if.unexp_rsp_o   = unexp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      unexp_q  <= 1'b0;
    end else begin
      if (accept) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)    rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (accept && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !accept) begin
        count_q <= count_q - 1'b1;
      end
      if (bus_if.bus_rvalid_i && (count_q == '0)) unexp_q <= 1'b1;
    end
  end

  // Entries are only read while count_q covers them, so the storage needs no reset.
  always_ff @(posedge clk_i) begin
    if (accept) id_q[wr_ptr_q] <= sel;
  end

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Self-checking bench for bus_host_arbiter: directed test-plan steps then randomized traffic against a queue model.
module tb_bus_host_arbiter;
  localparam int NrHosts = 2;
  localparam int MaxOut  = 2;
  localparam int DW      = 32;
  localparam int AW      = 32;
`ifdef BUS_ARB_FIXED_PRIO_EN
  localparam bit Fixed = 1'b1;
`else
  localparam bit Fixed = 1'b0;
`endif

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  bus_host_arbiter_if #(.NrHosts(NrHosts), .DataWidth(DW), .AddressWidth(AW)) bif();

  bus_host_arbiter #(
    .NrHosts(NrHosts), .MaxOutstanding(MaxOut), .DataWidth(DW), .AddressWidth(AW)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus_if (bif)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding host ids in issue order, round-robin start, sticky flag.
  int m_q[$];
  int m_rr    = 0;
  bit m_unexp = 1'b0;

  logic [NrHosts-1:0] req, we, eg;
  logic [AW-1:0]      addr  [NrHosts];
  logic [3:0]         be    [NrHosts];
  logic [DW-1:0]      wdata [NrHosts];
  logic               gnt, rvalid, err;
  logic [DW-1:0]      rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NrHosts; i++) begin
      bif.host_addr_i[i*AW +: AW]  = addr[i];
      bif.host_be_i[i*4 +: 4]      = be[i];
      bif.host_wdata_i[i*DW +: DW] = wdata[i];
    end
    bif.host_req_i   = req;
    bif.host_we_i    = we;
    bif.bus_gnt_i    = gnt;
    bif.bus_rvalid_i = rvalid;
    bif.bus_rdata_i  = rdata;
    bif.bus_err_i    = err;
  endtask

  function automatic int exp_sel(input logic [NrHosts-1:0] r);
    if (Fixed) begin
      for (int i = 0; i < NrHosts; i++) if (r[i]) return i;
    end else begin
      for (int k = 0; k < NrHosts; k++) if (r[(m_rr + k) % NrHosts]) return (m_rr + k) % NrHosts;
    end
    return 0;
  endfunction

  // One clock: apply inputs, check every output against the model, then advance the model.
  task automatic do_cycle(input string tag, output logic [NrHosts-1:0] exp_gnt);
    int s;
    bit any, breq, acc, pop;
    logic [NrHosts-1:0] ev, ee;
    @(negedge clk_i);
    drive();
    #1;
    any  = |req;
    breq = any && (m_q.size() < MaxOut);
    s    = exp_sel(req);
    acc  = breq && gnt;
    pop  = rvalid && (m_q.size() > 0);
    exp_gnt = acc ? (NrHosts'(1) << s) : '0;
    ev = pop ? (NrHosts'(1) << m_q[0]) : '0;
    ee = (pop && err) ? ev : '0;
    check({tag, ".bus_req"}, bif.bus_req_o, breq);
    if (breq) begin
      check({tag, ".bus_addr"}, bif.bus_addr_o, addr[s]);
      check({tag, ".bus_we"}, bif.bus_we_o, we[s]);
      check({tag, ".bus_be"}, bif.bus_be_o, be[s]);
      check({tag, ".bus_wdata"}, bif.bus_wdata_o, wdata[s]);
    end
    if (!any) check({tag, ".idle_addr"}, bif.bus_addr_o, '0);
    check({tag, ".gnt"}, bif.host_gnt_o, exp_gnt);
    check({tag, ".rvalid"}, bif.host_rvalid_o, ev);
    check({tag, ".err"}, bif.host_err_o, ee);
    check({tag, ".rdata"}, bif.host_rdata_o, rdata);
    check({tag, ".unexp"}, bif.unexp_rsp_o, m_unexp);
    if (pop) void'(m_q.pop_front());
    if (rvalid && !pop) m_unexp = 1'b1;
    if (acc) begin
      m_q.push_back(s);
      m_rr = (s + 1) % NrHosts;
    end
  endtask

  task automatic idle_inputs();
    req = '0; we = '0; gnt = 1'b0; rvalid = 1'b0; err = 1'b0; rdata = '0;
    for (int i = 0; i < NrHosts; i++) begin
      addr[i] = '0; be[i] = '0; wdata[i] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    idle_inputs();
    drive();
    rst_ni = 1'b0;
    #1;
    m_q.delete();
    m_rr    = 0;
    m_unexp = 1'b0;
    check("rst.bus_req", bif.bus_req_o, 1'b0);
    check("rst.gnt", bif.host_gnt_o, '0);
    check("rst.rvalid", bif.host_rvalid_o, '0);
    check("rst.err", bif.host_err_o, '0);
    check("rst.unexp", bif.unexp_rsp_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    idle_inputs();
    drive();
    do_reset();

    // Single host read with response one cycle later
    req = 2'b01; addr[0] = 32'h0010_0004; be[0] = 4'hF; gnt = 1'b1;
    do_cycle("single_req", eg);
    check("single.gnt_lit", bif.host_gnt_o, 2'b01);
    req = '0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    do_cycle("single_rsp", eg);
    check("single.rvalid_lit", bif.host_rvalid_o, 2'b01);
    check("single.rdata_lit", bif.host_rdata_o, 32'hDEAD_BEEF);
    check("single.unexp_lit", bif.unexp_rsp_o, 1'b0);
    rvalid = 1'b0;

    // Contention: both hosts requesting, each accept answered the following cycle
    do_reset();
    req = 2'b11; gnt = 1'b1; addr[0] = 32'hA000; addr[1] = 32'hB000;
    for (int i = 0; i < 4; i++) begin
      rvalid = (i != 0); rdata = 32'(i);
      do_cycle("contend", eg);
      check("contend.gnt_lit", bif.host_gnt_o, Fixed ? 2'b01 : ((i % 2) ? 2'b10 : 2'b01));
    end
    req = '0;
    do_cycle("contend_drain", eg);
    rvalid = 1'b0;

    // Backpressure: move rr_ptr to host1 first, then stall both requesters
    req = 2'b01; gnt = 1'b1;
    do_cycle("bp_pre", eg);
    req = '0; rvalid = 1'b1;
    do_cycle("bp_pre_rsp", eg);
    rvalid = 1'b0; req = 2'b11; gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_cycle("bp_stall", eg);
      check("bp.addr_lit", bif.bus_addr_o, Fixed ? 32'hA000 : 32'hB000);
    end
    gnt = 1'b1;
    do_cycle("bp_grant", eg);
    check("bp.gnt_lit", bif.host_gnt_o, Fixed ? 2'b01 : 2'b10);
    req = Fixed ? 2'b10 : 2'b01; rvalid = 1'b1;
    do_cycle("bp_next", eg);
    req = '0;
    do_cycle("bp_drain", eg);
    rvalid = 1'b0;

    // Outstanding limit with in-order response routing
    do_reset();
    req = 2'b11; gnt = 1'b1; addr[0] = 32'h10; addr[1] = 32'h20;
    do_cycle("lim_acc0", eg);
    do_cycle("lim_acc1", eg);
    do_cycle("lim_full", eg);
    check("lim.full_req_lit", bif.bus_req_o, 1'b0);
    rvalid = 1'b1; rdata = 32'h1111;
    do_cycle("lim_rsp0", eg);
    check("lim.rsp0_lit", bif.host_rvalid_o, 2'b01);
    check("lim.rsp0_req_lit", bif.bus_req_o, 1'b0);
    rdata = 32'h2222;
    do_cycle("lim_rsp1", eg);
    check("lim.unblock_lit", bif.bus_req_o, 1'b1);
    check("lim.rsp1_lit", bif.host_rvalid_o, Fixed ? 2'b01 : 2'b10);
    req = '0;
    do_cycle("lim_drain", eg);
    rvalid = 1'b0;

    // Error routing to host1
    do_reset();
    req = 2'b10; we = 2'b10; addr[1] = 32'h40; wdata[1] = 32'h5A5A_A5A5; be[1] = 4'h3; gnt = 1'b1;
    do_cycle("err_req", eg);
    check("err.gnt_lit", bif.host_gnt_o, 2'b10);
    req = '0; we = '0; rvalid = 1'b1; err = 1'b1;
    do_cycle("err_rsp", eg);
    check("err.err_lit", bif.host_err_o, 2'b10);
    check("err.rvalid_lit", bif.host_rvalid_o, 2'b10);
    rvalid = 1'b0; err = 1'b0;

    // Reset mid-operation, then a stale response
    req = 2'b01; gnt = 1'b1;
    do_cycle("unexp_req", eg);
    do_reset();
    rvalid = 1'b1;
    do_cycle("unexp_rsp", eg);
    check("unexp.rvalid_lit", bif.host_rvalid_o, 2'b00);
    rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_cycle("unexp_hold", eg);
      check("unexp.hold_lit", bif.unexp_rsp_o, 1'b1);
    end
    do_reset();

    // Randomized traffic; requesters hold req and payload until granted
    for (int c = 0; c < 400; c++) begin
      for (int h = 0; h < NrHosts; h++) begin
        if (!req[h] && ($urandom_range(0, 2) != 0)) begin
          req[h]   = 1'b1;
          addr[h]  = $urandom;
          we[h]    = 1'($urandom_range(0, 1));
          be[h]    = 4'($urandom_range(0, 15));
          wdata[h] = $urandom;
        end
      end
      gnt    = ($urandom_range(0, 3) != 0);
      rvalid = (m_q.size() > 0) && ($urandom_range(0, 1) != 0);
      rdata  = $urandom;
      err    = 1'($urandom_range(0, 1));
      do_cycle("rand", eg);
      req = req & ~eg;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_host_arbiter.md
Name: bus_host_arbiter

Overview:
- Multi-host front end for the system bus. Shares a single bus host port between NrHosts requesters, for example the core data port and a debug or DMA master.
- Arbitrates round-robin and forwards the winner's request downstream.
- Tracks outstanding transactions in an in-order ID FIFO, so each rvalid/rdata/err response is routed back to the host that issued it.
- Sits between the requesters and the bus host port 0.

Parameters:
- NrHosts, 2, number of upstream requesters (2..8).
- MaxOutstanding, 2, maximum accepted-but-unanswered transactions (power of 2, 1..8).
- DataWidth, 32, data width.
- AddressWidth, 32, address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- host_req_i  in  NrHosts  per-host request.
- host_gnt_o  out  NrHosts  per-host grant; the transfer is accepted in the cycle req&gnt.
- host_addr_i  in  NrHosts*AddressWidth  packed addresses; host i occupies slice i.
- host_we_i  in  NrHosts  write enables.
- host_be_i  in  NrHosts*4  byte enables.
- host_wdata_i  in  NrHosts*DataWidth  write data.
- host_rvalid_o  out  NrHosts  response valid, one-hot.
- host_rdata_o  out  DataWidth  response data, shared by all hosts and qualified by host_rvalid_o.
- host_err_o  out  NrHosts  response error, one-hot.
- bus_req_o  out  1  downstream request.
- bus_gnt_i  in  1  downstream grant.
- bus_addr_o  out  AddressWidth  downstream address.
- bus_we_o  out  1  downstream write enable.
- bus_be_o  out  4  downstream byte enables.
- bus_wdata_o  out  DataWidth  downstream write data.
- bus_rvalid_i  in  1  downstream response valid.
- bus_rdata_i  in  DataWidth  downstream response data.
- bus_err_i  in  1  downstream response error.
- unexp_rsp_o  out  1  sticky flag: a response arrived with no outstanding transaction.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values:
  - rr_ptr = 0.
  - Outstanding FIFO empty (count = 0).
  - unexp_rsp_o = 0.
  - All host_gnt_o, host_rvalid_o and host_err_o = 0.
  - bus_req_o = 0.
- Arbitration is combinational from the current host_req_i, rr_ptr and FIFO state.
  - sel = first requesting host searching from rr_ptr upward, wrapping modulo NrHosts.
  - No requester: bus_req_o = 0.
- Blocking: when count == MaxOutstanding, bus_req_o = 0 and no grant is given. A pop in the same cycle does not unblock; blocking is evaluated on the registered count.
- Forwarding: when not blocked, bus_req_o = 1 and bus_addr_o/we/be/wdata carry host sel's slices. With no requester, bus_addr_o/we/be/wdata are 0.
- Grant: host_gnt_o[sel] = bus_gnt_i & bus_req_o; all other grant bits are 0.
- Accept, when bus_req_o & bus_gnt_i:
  - Push sel into the FIFO.
  - rr_ptr <= (sel+1) mod NrHosts.
- rr_ptr changes only on accept. A stalled request (gnt = 0) keeps sel stable while that host holds req. Hosts must hold req and payload until granted.
- Response, when bus_rvalid_i with count > 0:
  - Pop the FIFO head h.
  - host_rvalid_o[h] = 1 and host_err_o[h] = bus_err_i, in the same cycle (combinational, zero latency).
  - host_rdata_o = bus_rdata_i always.
- Response with count == 0:
  - No host_rvalid_o asserted.
  - unexp_rsp_o set, held until reset.
- Simultaneous push and pop: count unchanged, pointers both advance.
- Responses are assumed in issue order; the downstream bus guarantees ordering.
- FIFO pointers are log2(MaxOutstanding) bits and wrap naturally. count is log2(MaxOutstanding)+1 bits.
- Reset mid-operation: the FIFO is flushed. Responses to transactions issued before reset then set unexp_rsp_o.

Optional Feature:
- Macro: BUS_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. rr_ptr is removed and sel = lowest-index requester.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Single host: host0 reads 0x100004, gnt = 1, rvalid next cycle with rdata 0xDEADBEEF -> host_gnt_o = 01, then host_rvalid_o = 01 with host_rdata_o = 0xDEADBEEF; unexp_rsp_o stays 0.
- Contention: both hosts hold req for 4 cycles, gnt = 1 -> grants alternate 01, 10, 01, 10. With BUS_ARB_FIXED_PRIO_EN defined -> 01 every cycle.
- Backpressure: gnt = 0 for 3 cycles while both hosts request -> sel, bus_addr_o and rr_ptr stay constant; the first grant goes to the original sel.
- Outstanding limit (MaxOutstanding = 2): two accepts with no response -> third-cycle bus_req_o = 0. One rvalid -> next cycle bus_req_o = 1. Responses route in order: host0 first, then host1.
- Error routing: host1 write accepted, response with bus_err_i = 1 -> host_err_o = 10, host_rvalid_o = 10.
- Unexpected response, reset mid-operation:
  - Stimulus: one accepted transaction, then rst_ni pulsed low, then bus_rvalid_i = 1.
  - Response: no host_rvalid_o, unexp_rsp_o = 1 and held until the next reset.
